// File: rtl/song_sequencer.sv
// song_sequencer: walks the note entries of a selected song in a 1-cycle-latency ROM and strobes each note to the player.
// Optional skip input is enabled by defining SONG_SEQ_SKIP_EN.
module song_sequencer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     play_i,
  input  logic [SONG_W-1:0]        song_i,
  input  logic                     loop_en_i,
  input  logic                     note_done_i,
`ifdef SONG_SEQ_SKIP_EN
  input  logic                     skip_i,
`endif
  output logic [SONG_W+IDX_W-1:0]  rom_addr_o,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data_i,
  output logic [NOTE_W-1:0]        note_o,
  output logic [DUR_W-1:0]         duration_o,
  output logic                     new_note_o,
  output logic                     song_done_o,
  output logic [IDX_W-1:0]         note_index_o
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, NEW_NOTE, PLAYING, DONE} state_t;
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                done_q, done_d;
  logic                adv, chg;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
`ifdef SONG_SEQ_SKIP_EN
  assign adv = note_done_i | skip_i;
`else
  assign adv = note_done_i;
`endif
  assign rom_note = rom_data_i[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data_i[DUR_W-1:0];
  // A new selection is only taken in IDLE when playback is about to start.
  assign chg = (song_i != song_q) && (state_q != IDLE || play_i);
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    song_d  = song_q;
    note_d  = note_q;
    dur_d   = dur_q;
    done_d  = done_q;
    if (chg) begin
      song_d  = song_i;
      index_d = '0;
      done_d  = 1'b0;
      state_d = play_i ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = play_i ? FETCH : IDLE;
        FETCH:    state_d = LOAD;
        LOAD:
          if (rom_dur != '0) begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            state_d = NEW_NOTE;
          end else if (loop_en_i && index_q != '0) begin
            index_d = '0;
            state_d = FETCH;
          end else state_d = DONE;
        NEW_NOTE: state_d = PLAYING;
        PLAYING:
          if (!play_i) state_d = IDLE;
          else if (adv) begin
            if (!(&index_q)) begin
              index_d = index_q + IDX_W'(1);
              state_d = FETCH;
            end else if (loop_en_i) begin
              index_d = '0;
              state_d = FETCH;
            end else state_d = DONE;
          end
        DONE:     state_d = DONE;
        default:  state_d = IDLE;
      endcase
    end
    if (state_d == DONE) begin
      done_d = 1'b1;
      note_d = '0;
      dur_d  = '0;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      index_q <= '0;
      song_q  <= song_i;
      note_q  <= '0;
      dur_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      song_q  <= song_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      done_q  <= done_d;
    end
  end
  assign rom_addr_o   = {song_q, index_q};
  assign note_o       = note_q;
  assign duration_o   = dur_q;
  assign new_note_o   = (state_q == NEW_NOTE);
  assign song_done_o  = done_q;
  assign note_index_o = index_q;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: randomized scoreboard bench; expected notes come from walking the ROM image with the song rules.
module tb_song_sequencer;
  localparam int NW = 6, DW = 6, SW = 2, IW = 5, N = 1 << IW;
  logic clk = 0, reset = 0, play = 0, loop_en = 0, note_done = 0, skip = 0;
  logic [SW-1:0] song = 0;
  logic [SW+IW-1:0] rom_addr;
  logic [NW+DW-1:0] rom_data;
  logic [NW-1:0] note;
  logic [DW-1:0] duration;
  logic new_note, song_done;
  logic [IW-1:0] note_index;
  logic [NW+DW-1:0] mem [1 << (SW+IW)];
  int cyc = 0, total = 0, bad = 0;
  typedef struct {int n; int d; int i; int c;} exp_t;
  exp_t q[$];
  int m_song = 0, m_idx = 0;
  bit m_done = 0, m_loop = 0;

  song_sequencer dut (
    .clk_i(clk), .reset_i(reset), .play_i(play), .song_i(song), .loop_en_i(loop_en),
    .note_done_i(note_done),
`ifdef SONG_SEQ_SKIP_EN
    .skip_i(skip),
`endif
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .note_o(note), .duration_o(duration),
    .new_note_o(new_note), .song_done_o(song_done), .note_index_o(note_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_data <= mem[rom_addr];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && new_note) begin
      exp_t e;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_new_note: got note %0d index %0d, want no strobe", note, note_index);
      end else begin
        e = q.pop_front();
        chk("note", {26'd0, note}, e.n);
        chk("duration", {26'd0, duration}, e.d);
        chk("note_index", {27'd0, note_index}, e.i);
        chk("new_note_cycle", cyc, e.c);
      end
    end
  end

  function automatic int dur_of(int s, int i);
    logic [NW+DW-1:0] w;
    w = mem[s*N + i];
    return int'(w[DW-1:0]);
  endfunction

  function automatic int note_of(int s, int i);
    logic [NW+DW-1:0] w;
    w = mem[s*N + i];
    return int'(w[NW+DW-1:DW]);
  endfunction

  // Next note reached when fetching starts at idx; each rewind through a zero entry costs two cycles.
  task automatic expect_from(int idx, int base);
    int extra = 0;
    forever begin
      if (dur_of(m_song, idx) != 0) begin
        q.push_back('{note_of(m_song, idx), dur_of(m_song, idx), idx, base + 3 + extra});
        m_idx = idx;
        m_done = 0;
        return;
      end
      if (m_loop && idx != 0) begin
        idx = 0;
        extra += 2;
      end else begin
        m_idx = idx;
        m_done = 1;
        return;
      end
    end
  endtask

  task automatic advance(int base);
    if (m_idx < N - 1) expect_from(m_idx + 1, base);
    else if (m_loop) expect_from(0, base);
    else m_done = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nn(string nm);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (new_note) return;
    end
    total++;
    bad++;
    $display("FAIL %s: no new_note within 40 cycles, want a strobe", nm);
  endtask

  task automatic step_note();
    repeat ($urandom_range(1, 3)) tick();
`ifdef SONG_SEQ_SKIP_EN
    if ($urandom % 2 == 1) skip = 1; else note_done = 1;
`else
    note_done = 1;
`endif
    advance(cyc);
    tick();
    note_done = 0;
    skip = 0;
  endtask

  task automatic check_done(string nm);
    repeat (8) tick();
    chk({nm, "_song_done"}, {31'd0, song_done}, 1);
    chk({nm, "_note_zero"}, {26'd0, note}, 0);
    chk({nm, "_dur_zero"}, {26'd0, duration}, 0);
    chk({nm, "_index_held"}, {27'd0, note_index}, m_idx);
  endtask

  task automatic play_notes(int n, bit start);
    if (start) begin
      tick();
      play = 1;
      expect_from(m_idx, cyc);
      if (m_done) begin
        check_done("empty");
        return;
      end
      wait_nn("first_note");
    end
    for (int k = 0; k < n && !m_done; k++) begin
      step_note();
      if (!m_done) wait_nn("next_note");
    end
    if (m_done) check_done("end");
  endtask

  task automatic do_reset(int s);
    play = 0; note_done = 0; skip = 0; song = SW'(s);
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    q.delete();
    m_song = s; m_idx = 0; m_done = 0;
  endtask

  task automatic pause();
    tick();
    play = 0;
    repeat (4) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < (1 << (SW+IW)); a++)
      mem[a] = {NW'($urandom_range(0, 63)), DW'($urandom_range(1, 63))};
    mem[32] = {6'd10, 6'd4};
    mem[33] = {6'd20, 6'd3};
    mem[34] = {6'd0, 6'd0};
    song = 1;
    reset = 1;
    #2;
    chk("rst_note", {26'd0, note}, 0);
    chk("rst_duration", {26'd0, duration}, 0);
    chk("rst_new_note", {31'd0, new_note}, 0);
    chk("rst_song_done", {31'd0, song_done}, 0);
    chk("rst_index", {27'd0, note_index}, 0);
    chk("rst_rom_addr", {25'd0, rom_addr}, 32'h20);
    do_reset(1);
    // Song 1: 10/4, 20/3, end marker.
    m_loop = 0; loop_en = 0;
    play_notes(5, 1);
    chk("done_rom_addr", {25'd0, rom_addr}, 32'h22);
    // Same song looping back through the end marker.
    do_reset(1);
    m_loop = 1; loop_en = 1;
    play_notes(5, 1);
    pause();
    chk("loop_song_done", {31'd0, song_done}, 0);
    loop_en = 0; m_loop = 0;
    // Full 32-entry song without an end marker.
    do_reset(2);
    play_notes(40, 1);
    // Pause with a simultaneous note_done at index 5, then resume.
    do_reset(2);
    play_notes(5, 1);
    tick();
    play = 0; note_done = 1;
    tick();
    note_done = 0;
    repeat (3) tick();
    chk("pause_index", {27'd0, note_index}, 5);
    chk("pause_rom_addr", {25'd0, rom_addr}, 32'h45);
    chk("pause_song_done", {31'd0, song_done}, 0);
    play_notes(2, 1);
    chk("pre_change_index", {27'd0, note_index}, 7);
    // Song change 2 -> 3 while playing.
    tick();
    song = 3; m_song = 3;
    expect_from(0, cyc);
    tick();
    chk("change_rom_addr", {25'd0, rom_addr}, 32'h60);
    chk("change_song_done", {31'd0, song_done}, 0);
    wait_nn("song_change");
    // Asynchronous reset between clock edges while playing.
    @(posedge clk);
    #3 reset = 1;
    #1;
    q.delete();
    chk("async_note", {26'd0, note}, 0);
    chk("async_duration", {26'd0, duration}, 0);
    chk("async_new_note", {31'd0, new_note}, 0);
    chk("async_song_done", {31'd0, song_done}, 0);
    chk("async_index", {27'd0, note_index}, 0);
    do_reset(3);
    // Random songs on song 0 with occasional end markers, random loop mode and pauses.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++)
        mem[i] = {NW'($urandom_range(0, 63)), ($urandom % 8 == 0) ? DW'(0) : DW'($urandom_range(1, 63))};
      m_loop = ($urandom % 2 == 1);
      loop_en = m_loop;
      do_reset(0);
      play_notes($urandom_range(3, 20), 1);
      if (!m_done) begin
        pause();
        play_notes($urandom_range(1, 4), 1);
      end
      if (!m_done) pause();
    end
    repeat (4) tick();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised song-playback sequencer; successor to the fixed 4-song/32-note reader.
- Walks note entries of a selected song in an external synchronous ROM.
- Presents note/duration to the note player with a one-cycle new_note strobe.
- Supports pause/resume, loop mode, mid-play song change and sticky end-of-song flag.

Parameters:
NOTE_W, 6, width of note code field
DUR_W, 6, width of duration field; duration 0 = end-of-song marker
SONG_W, 2, song select width (2^SONG_W songs)
IDX_W, 5, note index width (2^IDX_W entries per song)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
play  input  1  level; 1 = play/continue, 0 = pause
song  input  SONG_W  song select
loop_en  input  1  1 = restart song at index 0 instead of finishing
note_done  input  1  one-cycle pulse from note player: current note finished
rom_addr  output  SONG_W+IDX_W  {song_q, index}, registered-source, to song ROM
rom_data  input  NOTE_W+DUR_W  {note, duration}; valid one cycle after rom_addr is presented (1-cycle ROM latency)
note  output  NOTE_W  registered current note
duration  output  DUR_W  registered current duration
new_note  output  1  one-cycle strobe: note/duration updated
song_done  output  1  sticky end-of-song flag
note_index  output  IDX_W  current index (debug)

Behaviour:
- Reset (async, active-high): state IDLE, index 0, song_q = song, note 0, duration 0, new_note 0, song_done 0.
- States: IDLE, FETCH, LOAD, NEW_NOTE, PLAYING, DONE. All outputs registered or Moore-decoded.
- IDLE: play=1 -> FETCH; else stay. Index is held, so resume continues from the paused note.
- FETCH: rom_addr = {song_q, index} stable -> LOAD.
- LOAD: rom_data valid.
  - Duration field nonzero -> capture note/duration -> NEW_NOTE.
  - Duration 0 with loop_en=1 and index!=0 -> index 0 -> FETCH.
  - Otherwise (including an empty song: duration 0 at index 0) -> DONE.
- NEW_NOTE: new_note=1 for exactly this cycle -> PLAYING.
- PLAYING:
  - play=0 -> IDLE; index not advanced.
  - note_done=1 and index < 2^IDX_W-1 -> index+1 -> FETCH.
  - note_done=1 at last index: loop_en=1 -> index 0 -> FETCH; else -> DONE.
- DONE: song_done=1, note and duration forced to 0, index held. Stays until reset or song change; play and loop_en are ignored.
- Latency: play=1 sampled in IDLE -> new_note high in the 3rd cycle after that edge.
  - note_done -> next new_note: also 3 cycles.
- Song change: song != song_q in any non-IDLE state, or at the IDLE->FETCH decision:
  - song_q <= song, index 0, song_done 0, next state FETCH if play=1, else IDLE.
  - Song change has highest priority after reset.
- Priority in PLAYING: song change > play=0 > note_done.
- note_done outside PLAYING is ignored; it is never queued.
- Index arithmetic is modulo 2^IDX_W but wrap only occurs via the loop path. No overflow past the last index without loop.
- Reset mid-note: immediate return to reset values. new_note is never glitched high.

Optional Feature:
- Macro SONG_SEQ_SKIP_EN.
- Defined: adds input port skip (1 bit).
  - skip=1 in PLAYING behaves exactly as note_done (same end/loop rules).
  - skip has lower priority than play=0.
- Undefined: no skip port; behaviour as above.

Test Plan:
- Reset, song=1, play=1, ROM song1 = notes {10/4, 20/3, dur0} -> rom_addr 0x20, 0x21.
  - new_note 3 cycles after play with note=10, duration=4.
  - After note_done: note=20, duration=3.
  - After next note_done: song_done=1 and note=0, duration=0 held.
- Same song with loop_en=1 -> after the 2nd note_done, rom_addr returns to 0x20; new_note with note=10; song_done stays 0.
- Full 32-entry song, no zero duration, loop_en=0 -> after note_done at index 31, song_done=1 and no 33rd new_note.
- play dropped in PLAYING at index 5 with simultaneous note_done -> IDLE with index 5.
  - play=1 again -> re-fetch of address {song,5}.
- Song changed 2->3 while at index 7 with play=1 -> index 0, song_done 0, rom_addr 0x60, new_note 3 cycles later.
- reset asserted asynchronously mid-PLAYING (between clock edges) -> all outputs 0 immediately.
  - With SONG_SEQ_SKIP_EN: a skip pulse in PLAYING advances the index exactly like note_done.
